// File: rtl/memoria_pkg.sv
// Shared definitions for the parametrised instruction memory:
// FSM state encoding, default geometry and the default NOP word.
package memoria_pkg;

  // Loader / fetch controller states
  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CARGA    = 2'd1,
    EXECUCAO = 2'd2
  } estado_t;

  localparam int         LARGURA_DADO_PADRAO = 8;
  localparam int         LARGURA_END_PADRAO  = 8;
  localparam int         PROFUNDIDADE_PADRAO = 256;
  localparam logic [7:0] NOP_PADRAO          = 8'h00;

endpackage

// File: rtl/memoria_instrucoes_array.sv
// Instruction storage plus per-word "written" bits.
// Synchronous write port; registered read port that substitutes NOP for
// out-of-range or never-written words. The data array itself is not reset.
module memoria_instrucoes_array
  import memoria_pkg::*;
#(
  parameter int                      LARGURA_DADO = LARGURA_DADO_PADRAO,
  parameter int                      LARGURA_END  = LARGURA_END_PADRAO,
  parameter int                      PROFUNDIDADE = PROFUNDIDADE_PADRAO,
  parameter logic [LARGURA_DADO-1:0] NOP          = NOP_PADRAO
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    limpa,
  input  logic                    escreve,
  input  logic [LARGURA_END-1:0]  end_escrita,
  input  logic [LARGURA_DADO-1:0] dado_escrita,
  input  logic                    le,
  input  logic [LARGURA_END-1:0]  end_leitura,
  output logic                    acerto,
  output logic [LARGURA_DADO-1:0] dado_leitura
);

  localparam logic [LARGURA_END:0] LIMITE = (LARGURA_END+1)'(PROFUNDIDADE);

  logic [LARGURA_DADO-1:0] mem_r [0:PROFUNDIDADE-1];
  logic [PROFUNDIDADE-1:0] escrito_r;
  logic [LARGURA_DADO-1:0] dado_leitura_r;
  logic                    dentro_s;
  logic [LARGURA_END-1:0]  idx_s;

  // Out-of-range addresses are folded to 0 so no index ever leaves the array;
  // dentro_s still forces them to miss.
  assign dentro_s     = ({1'b0, end_leitura} < LIMITE);
  assign idx_s        = dentro_s ? end_leitura : {LARGURA_END{1'b0}};
  assign acerto       = dentro_s && escrito_r[idx_s];
  assign dado_leitura = dado_leitura_r;

  // Storage write port (no reset on the data array)
  always_ff @(posedge clk) begin
    if (escreve) begin
      mem_r[end_escrita] <= dado_escrita;
    end
  end

  // Written-bit tracking: cleared on reset and on every (re)load start
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      escrito_r <= {PROFUNDIDADE{1'b0}};
    end else if (limpa) begin
      escrito_r <= {PROFUNDIDADE{1'b0}};
    end else if (escreve) begin
      escrito_r[end_escrita] <= 1'b1;
    end
  end

  // Registered read port; holds its value between reads
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dado_leitura_r <= NOP;
    end else if (le) begin
      dado_leitura_r <= acerto ? mem_r[idx_s] : NOP;
    end
  end

endmodule

// File: rtl/memoria_instrucoes_param.sv
// Parametrised instruction memory: a loader streams the program in after
// reset (CARGA), then the fetch stage reads it with one-cycle latency
// (EXECUCAO). Unwritten or out-of-range fetches return NOP and flag an error.
module memoria_instrucoes_param
  import memoria_pkg::*;
#(
  parameter int                      LARGURA_DADO = LARGURA_DADO_PADRAO,
  parameter int                      LARGURA_END  = LARGURA_END_PADRAO,
  parameter int                      PROFUNDIDADE = PROFUNDIDADE_PADRAO,
  parameter logic [LARGURA_DADO-1:0] NOP          = NOP_PADRAO
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    carga_inicio,
  input  logic                    carga_valido,
  input  logic [LARGURA_DADO-1:0] carga_dado,
  input  logic                    carga_fim,
  output logic                    carregado,
  output logic [LARGURA_END:0]    palavras,
  output logic                    estouro,
  input  logic                    req,
  input  logic [LARGURA_END-1:0]  endereco,
  output logic [LARGURA_DADO-1:0] instrucao,
  output logic                    instrucao_valida,
  output logic                    erro_endereco
);

  localparam logic [LARGURA_END:0] LIMITE       = (LARGURA_END+1)'(PROFUNDIDADE);
  localparam logic [LARGURA_END:0] LIMITE_MENOS = (LARGURA_END+1)'(PROFUNDIDADE - 1);
  localparam logic [LARGURA_END:0] UM           = {{LARGURA_END{1'b0}}, 1'b1};

  estado_t              estado_r;
  logic [LARGURA_END:0] ponteiro_r;
  logic                 estouro_r;
  logic                 carregado_r;
  logic                 auto_r;
  logic                 valida_r;
  logic                 erro_r;

  logic busca_s;
  logic escreve_s;
  logic auto_s;
  logic descarta_s;
  logic acerto_s;

  // A load start always wins over a fetch or a write in the same cycle.
  assign busca_s    = (estado_r == EXECUCAO) && req && !carga_inicio;
  assign escreve_s  = (estado_r == CARGA) && carga_valido && !carga_inicio &&
                      (ponteiro_r < LIMITE);
  assign auto_s     = escreve_s && (ponteiro_r == LIMITE_MENOS);
  // auto_r marks the cycle right after the memory filled up: a word offered
  // then is the one that did not fit.
  assign descarta_s = auto_r && carga_valido && !carga_inicio;

  assign carregado        = carregado_r;
  assign palavras         = ponteiro_r;
  assign estouro          = estouro_r;
  assign instrucao_valida = valida_r;
  assign erro_endereco    = erro_r;

  memoria_instrucoes_array #(
    .LARGURA_DADO (LARGURA_DADO),
    .LARGURA_END  (LARGURA_END),
    .PROFUNDIDADE (PROFUNDIDADE),
    .NOP          (NOP)
  ) u_array (
    .clk          (clk),
    .rst_n        (rst_n),
    .limpa        (carga_inicio),
    .escreve      (escreve_s),
    .end_escrita  (ponteiro_r[LARGURA_END-1:0]),
    .dado_escrita (carga_dado),
    .le           (busca_s),
    .end_leitura  (endereco),
    .acerto       (acerto_s),
    .dado_leitura (instrucao)
  );

  // Controller FSM with write pointer, flags and fetch-response registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado_r    <= OCIOSO;
      ponteiro_r  <= {(LARGURA_END+1){1'b0}};
      estouro_r   <= 1'b0;
      carregado_r <= 1'b0;
      auto_r      <= 1'b0;
      valida_r    <= 1'b0;
      erro_r      <= 1'b0;
    end else begin
      auto_r   <= 1'b0;
      valida_r <= busca_s;
      erro_r   <= busca_s && !acerto_s;
      if (descarta_s) begin
        estouro_r <= 1'b1;
      end
      case (estado_r)
        OCIOSO: begin
          if (carga_inicio) begin
            estado_r    <= CARGA;
            ponteiro_r  <= {(LARGURA_END+1){1'b0}};
            estouro_r   <= 1'b0;
            carregado_r <= 1'b0;
          end
        end
        CARGA: begin
          if (carga_inicio) begin
            ponteiro_r <= {(LARGURA_END+1){1'b0}};
            estouro_r  <= 1'b0;
          end else begin
            if (escreve_s) begin
              ponteiro_r <= ponteiro_r + UM;
            end
            if (carga_fim || auto_s) begin
              estado_r    <= EXECUCAO;
              carregado_r <= 1'b1;
              auto_r      <= auto_s;
            end
          end
        end
        EXECUCAO: begin
          if (carga_inicio) begin
            estado_r    <= CARGA;
            ponteiro_r  <= {(LARGURA_END+1){1'b0}};
            estouro_r   <= 1'b0;
            carregado_r <= 1'b0;
          end
        end
        default: begin
          estado_r    <= OCIOSO;
          ponteiro_r  <= {(LARGURA_END+1){1'b0}};
          estouro_r   <= 1'b0;
          carregado_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memoria_instrucoes_param.sv
// Directed bench for memoria_instrucoes_param (PROFUNDIDADE = 200, NOP = 0xF0).
// Expected fetch responses are queued when a request is driven and compared
// when the DUT reports a response.
module tb_memoria_instrucoes_param;

  localparam logic [7:0] NOP_V = 8'hF0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       carga_inicio;
  logic       carga_valido;
  logic [7:0] carga_dado;
  logic       carga_fim;
  logic       carregado;
  logic [8:0] palavras;
  logic       estouro;
  logic       req;
  logic [7:0] endereco;
  logic [7:0] instrucao;
  logic       instrucao_valida;
  logic       erro_endereco;

  int n_asserts = 0;
  int n_fails   = 0;

  typedef struct packed {
    logic [7:0] instr;
    logic       erro;
  } resp_t;

  resp_t fila[$];

  memoria_instrucoes_param #(
    .LARGURA_DADO (8),
    .LARGURA_END  (8),
    .PROFUNDIDADE (200),
    .NOP          (NOP_V)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .carga_inicio     (carga_inicio),
    .carga_valido     (carga_valido),
    .carga_dado       (carga_dado),
    .carga_fim        (carga_fim),
    .carregado        (carregado),
    .palavras         (palavras),
    .estouro          (estouro),
    .req              (req),
    .endereco         (endereco),
    .instrucao        (instrucao),
    .instrucao_valida (instrucao_valida),
    .erro_endereco    (erro_endereco)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; sample 1 time unit after the edge and score the response slot
  task automatic passo();
    resp_t r;
    @(posedge clk);
    #1;
    if (fila.size() > 0) begin
      r = fila.pop_front();
      check("valida", {31'd0, instrucao_valida}, 32'd1);
      check("instrucao", {24'd0, instrucao}, {24'd0, r.instr});
      check("erro_endereco", {31'd0, erro_endereco}, {31'd0, r.erro});
    end else begin
      check("valida_ociosa", {31'd0, instrucao_valida}, 32'd0);
    end
  endtask

  task automatic pede(input logic [7:0] a, input logic [7:0] instr, input logic erro);
    resp_t r;
    r.instr  = instr;
    r.erro   = erro;
    req      = 1'b1;
    endereco = a;
    fila.push_back(r);
    passo();
    req = 1'b0;
  endtask

  task automatic escreve(input logic [7:0] d);
    carga_valido = 1'b1;
    carga_dado   = d;
    passo();
    carga_valido = 1'b0;
  endtask

  task automatic inicia();
    carga_inicio = 1'b1;
    passo();
    carga_inicio = 1'b0;
  endtask

  task automatic termina();
    carga_fim = 1'b1;
    passo();
    carga_fim = 1'b0;
  endtask

  task automatic checa_reset(input string tag);
    check({tag, "_carregado"}, {31'd0, carregado}, 32'd0);
    check({tag, "_palavras"}, {23'd0, palavras}, 32'd0);
    check({tag, "_estouro"}, {31'd0, estouro}, 32'd0);
    check({tag, "_instrucao"}, {24'd0, instrucao}, {24'd0, NOP_V});
    check({tag, "_valida"}, {31'd0, instrucao_valida}, 32'd0);
    check({tag, "_erro"}, {31'd0, erro_endereco}, 32'd0);
  endtask

  initial begin
    rst_n        = 1'b0;
    carga_inicio = 1'b0;
    carga_valido = 1'b0;
    carga_dado   = 8'h00;
    carga_fim    = 1'b0;
    req          = 1'b0;
    endereco     = 8'h00;

    // Reset values
    passo();
    passo();
    checa_reset("reset");
    rst_n = 1'b1;

    // Fetch before any load: ignored
    req      = 1'b1;
    endereco = 8'h00;
    passo();
    req = 1'b0;
    passo();
    check("ocioso_carregado", {31'd0, carregado}, 32'd0);

    // Load three words, then end the load
    inicia();
    check("carga_carregado", {31'd0, carregado}, 32'd0);
    escreve(8'h11);
    escreve(8'h22);
    escreve(8'h33);
    check("carga_palavras3", {23'd0, palavras}, 32'd3);
    termina();
    check("fim_carregado", {31'd0, carregado}, 32'd1);

    // Back-to-back fetches 0..3, plus an address beyond PROFUNDIDADE
    pede(8'd0, 8'h11, 1'b0);
    pede(8'd1, 8'h22, 1'b0);
    pede(8'd2, 8'h33, 1'b0);
    pede(8'd3, NOP_V, 1'b1);
    pede(8'd255, NOP_V, 1'b1);
    passo();

    // Full load of 201 words: auto-transition after word 200, word 201 dropped
    inicia();
    check("recarga_carregado", {31'd0, carregado}, 32'd0);
    check("recarga_palavras", {23'd0, palavras}, 32'd0);
    for (int i = 0; i < 201; i++) begin
      escreve(8'(i) ^ 8'h5A);
      if (i == 199) begin
        check("auto_carregado", {31'd0, carregado}, 32'd1);
        check("auto_palavras", {23'd0, palavras}, 32'd200);
        check("auto_estouro_antes", {31'd0, estouro}, 32'd0);
      end
    end
    check("estouro", {31'd0, estouro}, 32'd1);
    check("cheio_palavras", {23'd0, palavras}, 32'd200);
    pede(8'd0, 8'h5A, 1'b0);
    pede(8'd199, 8'(199) ^ 8'h5A, 1'b0);
    pede(8'd200, NOP_V, 1'b1);

    // Reload with a single word invalidates the old contents
    inicia();
    check("reload_estouro", {31'd0, estouro}, 32'd0);
    escreve(8'hAA);
    termina();
    check("reload_palavras", {23'd0, palavras}, 32'd1);
    escreve(8'hBB);
    check("valido_fora_carga", {23'd0, palavras}, 32'd1);
    pede(8'd1, NOP_V, 1'b1);
    pede(8'd0, 8'hAA, 1'b0);
    passo();
    check("instrucao_mantida", {24'd0, instrucao}, 32'hAA);

    // Last word written together with carga_fim
    inicia();
    escreve(8'h3C);
    carga_valido = 1'b1;
    carga_dado   = 8'h5C;
    carga_fim    = 1'b1;
    passo();
    carga_valido = 1'b0;
    carga_fim    = 1'b0;
    check("valido_fim_carregado", {31'd0, carregado}, 32'd1);
    check("valido_fim_palavras", {23'd0, palavras}, 32'd2);
    pede(8'd1, 8'h5C, 1'b0);
    pede(8'd0, 8'h3C, 1'b0);
    pede(8'd2, NOP_V, 1'b1);

    // req together with carga_inicio: load wins, no response
    req          = 1'b1;
    endereco     = 8'd0;
    carga_inicio = 1'b1;
    passo();
    req          = 1'b0;
    carga_inicio = 1'b0;
    check("req_inicio_carregado", {31'd0, carregado}, 32'd0);

    // Restart during CARGA drops the simultaneous word
    escreve(8'h77);
    carga_inicio = 1'b1;
    carga_valido = 1'b1;
    carga_dado   = 8'h88;
    passo();
    carga_inicio = 1'b0;
    carga_valido = 1'b0;
    check("restart_palavras", {23'd0, palavras}, 32'd0);
    escreve(8'h99);
    termina();
    check("restart_palavras1", {23'd0, palavras}, 32'd1);
    pede(8'd0, 8'h99, 1'b0);
    pede(8'd1, NOP_V, 1'b1);

    // Reset coinciding with a fetch request discards it
    req      = 1'b1;
    endereco = 8'd0;
    rst_n    = 1'b0;
    passo();
    req = 1'b0;
    checa_reset("reset_busca");
    rst_n = 1'b1;
    passo();
    checa_reset("pos_reset");
    req = 1'b1;
    passo();
    req = 1'b0;
    passo();

    check("fila_vazia", fila.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
